clock_run_sequencer: RTL

//  Run/halt/single-step controller for the machine clock. Wraps a programmable divider
//  and decides when the divided clock may run. Emits a one-cycle Tick enable and a

---
 rtl/clock_run_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/clock_run_sequencer.sv
// clock_run_sequencer: run/halt/single-step controller around a programmable clock divider.
module clock_run_sequencer #(
  parameter int               CNT_W      = 28,
  parameter logic [CNT_W-1:0] DIV_SLOW   = 28'd50000000,
  parameter logic [CNT_W-1:0] DIV_MED    = 28'd5000000,
  parameter logic [CNT_W-1:0] DIV_FAST   = 28'd50000,
  parameter int               DUTY_CYCLE = 50
) (
  input  logic       clock_in,
  input  logic       Rst,
  input  logic       Run,
  input  logic       Step,
  input  logic       Halt,
  input  logic [1:0] Speed,
  output logic       Tick,
  output logic       clock_out,
  output logic       Running,
  output logic       Halted,
  output logic       Step_done
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, DRAIN} state_t;
  state_t state, ns;
  logic [CNT_W-1:0] cnt, cnt_n, div_act, div_n, hi_cnt, hi_n, div_sel;
  logic ld, last, halted_n, done_n;
  // high time uses a double-width product so large divisors cannot overflow
  function automatic logic [CNT_W-1:0] hi_of(input logic [CNT_W-1:0] d);
    logic [2*CNT_W-1:0] p;
    p = ((2*CNT_W)'(d) * (2*CNT_W)'(DUTY_CYCLE)) / (2*CNT_W)'(100);
    return p == '0 ? CNT_W'(1) : p[CNT_W-1:0];
  endfunction
  assign div_sel = Speed == 2'd0 ? DIV_SLOW : Speed == 2'd1 ? DIV_MED :
                   Speed == 2'd2 ? DIV_FAST : CNT_W'(1);
  assign last = cnt == div_act - CNT_W'(1);
  always_comb begin
    ns = state;
    cnt_n = cnt;
    ld = 1'b0;
    halted_n = Halted | Halt;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!Halt && Run && !Halted) begin
          ns = RUN;
          ld = 1'b1;
        end else if (!Halt && !Run) begin
          halted_n = 1'b0;
          if (Step) begin
            ns = STEP;
            ld = 1'b1;
          end
        end
      end
      RUN: begin
        if (last) begin
          cnt_n = '0;
          if (!Run || Halt) ns = IDLE;
          else ld = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (!Run || Halt) ns = DRAIN;
        end
      end
      STEP, DRAIN: begin
        if (last) begin
          cnt_n = '0;
          ns = IDLE;
          done_n = state == STEP;
        end else cnt_n = cnt + CNT_W'(1);
      end
      default: ns = IDLE;
    endcase
    div_n = ld ? div_sel : div_act;
    hi_n = ld ? hi_of(div_sel) : hi_cnt;
  end
  always_ff @(posedge clock_in or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      div_act <= DIV_SLOW;
      hi_cnt <= hi_of(DIV_SLOW);
      Tick <= 1'b0;
      clock_out <= 1'b0;
      Running <= 1'b0;
      Halted <= 1'b0;
      Step_done <= 1'b0;
    end else begin
      state <= ns;
      cnt <= cnt_n;
      div_act <= div_n;
      hi_cnt <= hi_n;
      Tick <= (ns == RUN || ns == STEP) && cnt_n == '0;
      clock_out <= ns != IDLE && cnt_n < hi_n;
      Running <= ns != IDLE;
      Halted <= halted_n;
      Step_done <= done_n;
    end
  end
endmodule
